// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-hot multi-stage sequencer with stall timeout, trap/interrupt op select, double-fault halt
// Optional retired-instruction counter enabled by defining RETIRED_COUNT_EN.
module stage_sequencer #(
  parameter int NUM_STAGES   = 7,
  parameter int FAULT_BITS   = 3,
  parameter int MAX_WAIT     = 15,
  parameter int TIMEOUT_CODE = 5,
  parameter int COUNT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NUM_STAGES-1:0] stage_skip,
  input  logic                  fault,
  input  logic [FAULT_BITS-1:0] fault_code,
  input  logic                  ext_int,
  input  logic                  sw_int,
  output logic [NUM_STAGES-1:0] stage_active,
  output logic [1:0]            control_op,
  output logic [FAULT_BITS-1:0] fault_num,
  output logic                  halted
`ifdef RETIRED_COUNT_EN
  ,
  output logic [COUNT_BITS-1:0] retired_count
`endif
);

  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] OP_TRAP   = 2'b00;
  localparam logic [1:0] OP_EXT    = 2'b01;
  localparam logic [1:0] OP_SW     = 2'b10;
  localparam logic [1:0] OP_NORMAL = 2'b11;

  typedef enum logic {RUN, HALT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    stage_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    next_idx;
  logic                wrap;
  logic                timeout;
  logic                eff_fault;
  logic [FAULT_BITS-1:0] eff_code;

  // Descending scan so the last hit is the smallest non-skipped stage above the current one.
  always_comb begin
    next_idx = '0;
    wrap     = 1'b1;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (j > int'(stage_idx) && !stage_skip[j]) begin
        next_idx = IDX_W'(j);
        wrap     = 1'b0;
      end
    end
  end

  assign timeout   = stall && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign eff_fault = fault || timeout;
  assign eff_code  = fault ? fault_code : FAULT_BITS'(TIMEOUT_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      stage_idx    <= '0;
      stage_active <= NUM_STAGES'(1);
      control_op   <= OP_NORMAL;
      fault_num    <= '0;
      halted       <= 1'b0;
      wait_cnt     <= '0;
`ifdef RETIRED_COUNT_EN
      retired_count <= '0;
`endif
    end else if (state == RUN) begin
      if (eff_fault) begin
        wait_cnt <= '0;
        if (control_op == OP_TRAP) begin
          state        <= HALT;
          halted       <= 1'b1;
          stage_active <= '0;
        end else begin
          stage_idx    <= '0;
          stage_active <= NUM_STAGES'(1);
          control_op   <= OP_TRAP;
          fault_num    <= eff_code;
        end
      end else if (stall) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt     <= '0;
        stage_idx    <= next_idx;
        stage_active <= NUM_STAGES'(1) << next_idx;
        if (wrap) begin
          if (ext_int)     control_op <= OP_EXT;
          else if (sw_int) control_op <= OP_SW;
          else             control_op <= OP_NORMAL;
`ifdef RETIRED_COUNT_EN
          if (control_op == OP_NORMAL) retired_count <= retired_count + COUNT_BITS'(1);
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && state == RUN) assert ($onehot(stage_active));
  end

endmodule
